// File: rtl/rv_mem_arbiter.sv
// Arbitrates one single-port sync memory between instruction fetch and load/store; data has priority.
// Latency req->ready is MEM_LAT+2 cycles; requesters hold req until their one-cycle ready pulse.
module rv_mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state;
  logic        gnt;
  logic        wr;
  logic [3:0]  streak;
  logic [2:0]  wcnt;
  logic        grant_d;
  logic        grant_i;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  // Data wins a tie unless fetch has already been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_d = d_req && !(i_req && (streak == 4'(STARVE_MAX)));
    grant_i = i_req && !grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      wr        <= 1'b0;
      streak    <= 4'd0;
      wcnt      <= 3'd0;
      mem_en    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wen   <= 4'd0;
      mem_wdata <= 32'd0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            gnt       <= 1'b1;
            wr        <= |d_wen;
            mem_en    <= 1'b1;
            mem_addr  <= {d_addr[31:2], 2'b00};
            mem_wen   <= d_wen;
            mem_wdata <= d_wdata;
            streak    <= i_req ? streak + 4'd1 : 4'd0;
            state     <= ACCESS;
          end else if (grant_i) begin
            gnt       <= 1'b0;
            wr        <= 1'b0;
            mem_en    <= 1'b1;
            mem_addr  <= {i_addr[31:2], 2'b00};
            mem_wen   <= 4'd0;
            mem_wdata <= 32'd0;
            streak    <= 4'd0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en  <= 1'b0;
          mem_wen <= 4'd0;
          wcnt    <= 3'(MEM_LAT - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (wcnt == 3'd0) begin
            if (!gnt)
              i_rdata <= mem_rdata;
            else if (!wr)
              d_rdata <= mem_rdata;
            i_ready <= !gnt;
            d_ready <= gnt;
            state   <= DONE;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Shares one single-port synchronous memory between the core's instruction-fetch requester and its load/store requester. Each requester uses a req/ready handshake. The block grants one requester per transaction, sequences the memory access through a fixed-latency state machine, and returns read data in a per-port holding register. Data accesses have priority, and a starvation guard guarantees instruction fetch progress.

## Interface
Parameters:
- MEM_LAT, 1: memory read latency in cycles, from the cycle `mem_en` is high to the cycle `mem_rdata` is valid. Legal range 1..8.
- STARVE_MAX, 4: maximum consecutive data grants while `i_req` is pending; the next grant then goes to instruction. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  instruction read request; held until `i_ready`.
- i_addr  in  32  instruction byte address.
- i_ready  out  1  one-cycle completion pulse for the instruction port.
- i_rdata  out  32  last instruction word read; held between completions.
- d_req  in  1  data request; held until `d_ready`.
- d_addr  in  32  data byte address.
- d_wen  in  4  byte write enables; 0 means read, nonzero means write.
- d_wdata  in  32  write data, byte lanes aligned to the word.
- d_ready  out  1  one-cycle completion pulse for the data port.
- d_rdata  out  32  last data word read; held between read completions.
- mem_en  out  1  memory access strobe.
- mem_addr  out  32  word address: {addr[31:2], 2'b00}.
- mem_wen  out  4  memory byte write enables.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.

## Operation
- States: IDLE, ACCESS, WAIT, DONE. A one-bit register `gnt` records the owner (0 = instruction, 1 = data).
- IDLE:
  - No request: stay in IDLE.
  - `d_req` only: grant data.
  - `i_req` only: grant instruction.
  - Both requests: grant data unless `streak == STARVE_MAX`, then grant instruction.
  - On a grant: latch addr/wen/wdata of the granted port into the memory output registers and go to ACCESS.
- ACCESS (1 cycle):
  - `mem_en = 1`, `mem_addr`, `mem_wen` and `mem_wdata` are driven from registers.
  - `mem_wen = 0` for instruction grants.
  - Go to WAIT and load the wait counter with MEM_LAT-1.
- WAIT:
  - `mem_en = 0` and `mem_wen = 0`; `mem_addr` and `mem_wdata` hold.
  - When the counter reaches 0, `mem_rdata` is valid this cycle:
    - Capture it into `i_rdata` if gnt=0.
    - Capture it into `d_rdata` if gnt=1 and the access was a read.
    - Go to DONE.
  - Otherwise decrement the counter.
- DONE (1 cycle): `i_ready` = (gnt==0) and `d_ready` = (gnt==1), then go to IDLE.
- Streak counter (4 bits):
  - Incremented on a data grant while `i_req` = 1.
  - Cleared on an instruction grant.
  - Cleared on a data grant while `i_req` = 0.
  - Never exceeds STARVE_MAX.
- Writes complete in memory during ACCESS. `d_ready` still follows the full read timing; `d_rdata` is unchanged by writes.
- Requester rule: hold req and inputs stable from assertion through the ready cycle. In the cycle after ready, drop req or present the next request.
- Requests that change or drop while not granted are simply re-evaluated in IDLE; no error is flagged.
- Address bits [1:0] are ignored; no misalignment detection.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State goes to IDLE; gnt, streak and the wait counter go to 0.
  - Every output goes to 0: `mem_en`, `mem_addr`, `mem_wen`, `mem_wdata`, `i_ready`, `d_ready`, `i_rdata`, `d_rdata`.
  - Reset during ACCESS drops `mem_en` and `mem_wen` immediately; a write in that cycle is not guaranteed.
  - Reset during WAIT or DONE discards the transaction; no ready pulse is issued.
- Latency: req seen in IDLE at cycle T → ACCESS at T+1 → `mem_rdata` sampled at T+1+MEM_LAT → ready high at T+2+MEM_LAT (3 cycles for MEM_LAT=1).
- Throughput: one transaction per MEM_LAT+3 cycles (IDLE, ACCESS, WAIT×MEM_LAT, DONE).
- Back-to-back: a request held high through DONE is granted in the following IDLE cycle.
- `i_ready` and `d_ready` are never high in the same cycle.
- Ready is never high outside DONE.
- `mem_en` is high exactly one cycle per transaction.

## Test plan
- Reset, then `i_req` with `i_addr` = 0x0000_0106, MEM_LAT=1, memory returns 0xDEAD_BEEF:
  - ACCESS with `mem_addr` = 0x104, `mem_wen` = 0.
  - `i_ready` pulses 3 cycles after `i_req`, with `i_rdata` = 0xDEAD_BEEF.
  - `d_ready` stays 0.
- Data write: `d_addr` = 0x200, `d_wen` = 4'b0011, `d_wdata` = 0x1234_5678:
  - One ACCESS cycle with `mem_wen` = 0011 and `mem_wdata` = 0x1234_5678.
  - `d_ready` pulses once; `d_rdata` unchanged.
- Both requests held continuously, STARVE_MAX=4:
  - Grant order is D, D, D, D, I, D, D, D, D, I.
  - `streak` returns to 0 after each I grant.
- MEM_LAT=3 read:
  - `mem_en` high 1 cycle, WAIT lasts 3 cycles.
  - `d_ready` arrives 5 cycles after `d_req`.
  - `d_rdata` equals the memory value present in the last WAIT cycle.
- Assert `rst` = 0 in the WAIT cycle of an instruction read:
  - All outputs 0 asynchronously; no `i_ready` pulse afterwards.
  - After release with `i_req` still high, the fetch restarts from IDLE with full latency.
- Data-only stream with `i_req` = 0:
  - `streak` stays 0.
  - Asserting `i_req` mid-stream: the next 4 grants go to data, then the next to instruction.
